// File: rtl/risc16_pkg.sv
// Shared types for the RISC16 pipeline family: machine word and the
// {pc, instr} pair that the fetch queue hands to decode.
package risc16_pkg;

  localparam int XLEN = 16;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam word_t NOP = '0;

endpackage

// File: rtl/risc16_iq_ram.sv
// Fetch-queue storage: DEPTH x WIDTH register array, one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module risc16_iq_ram
  import risc16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/risc16_ifetch_queue.sv
// Instruction-fetch unit: owns the fetch PC, reads an async instruction
// memory, and buffers {pc, instr} pairs for decode behind a valid/ready port.
module risc16_ifetch_queue
  import risc16_pkg::*;
#(
  parameter int               XLEN     = risc16_pkg::XLEN,
  parameter int               DEPTH    = 4,
  parameter int               PC_STEP  = 2,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [XLEN-1:0]            i_addr,
  output logic                       i_oe,
  input  logic [XLEN-1:0]            i_din,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic [XLEN-1:0]            q_instr,
  output logic [XLEN-1:0]            q_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("risc16_ifetch_queue: DEPTH must be a power of two >= 2");
  end

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, valid;
  logic [2*XLEN-1:0] rd_entry;

  // Full blocks fetch even when decode is popping the same cycle.
  assign push  = !rst && !redirect_valid && (count_q != FULL);
  assign valid = !rst && (count_q != '0);
  assign pop   = valid && q_ready;

  // Redirect flushes everything and overrides any same-cycle push or pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  risc16_iq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({fetch_pc_q, i_din}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign i_addr  = fetch_pc_q;
  assign i_oe    = push;
  assign q_valid = valid;
  assign q_pc    = valid ? rd_entry[2*XLEN-1:XLEN] : '0;
  assign q_instr = valid ? rd_entry[XLEN-1:0] : XLEN'(NOP);
  assign q_count = rst ? '0 : count_q;

endmodule

// File: tb/tb_risc16_ifetch_queue.sv
// Bench for risc16_ifetch_queue: a hand-computed vector table for fill,
// back-pressure, redirect and reset, then a queue-based model for streaming,
// wrap, held redirect and random traffic.
module tb_risc16_ifetch_queue;

  localparam int MODE_NONE  = 0;
  localparam int MODE_TABLE = 1;
  localparam int MODE_MODEL = 2;

  typedef struct packed {
    logic        rst;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic [15:0] eAddr;
    logic        eOe;
    logic        eValid;
    logic [15:0] ePc;
    logic [2:0]  eCount;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr;
  logic        i_oe;
  logic [15:0] i_din;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        q_valid;
  logic        q_ready;
  logic [15:0] q_instr;
  logic [15:0] q_pc;
  logic [2:0]  q_count;

  int checks = 0;
  int passes = 0;

  logic [15:0] mPc;
  logic [15:0] sbq[$];
  logic [15:0] capQ[$];
  bit          capture = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory model: the word stored at each address is the address.
  assign i_din = i_addr;

  risc16_ifetch_queue #(
    .XLEN     (16),
    .DEPTH    (4),
    .PC_STEP  (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_addr         (i_addr),
    .i_oe           (i_oe),
    .i_din          (i_din),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .q_valid        (q_valid),
    .q_ready        (q_ready),
    .q_instr        (q_instr),
    .q_pc           (q_pc),
    .q_count        (q_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input bit r, input bit rv, input logic [15:0] rpc, input bit rdy,
                               input int mode, input vec_t v, input string tag);
    logic [15:0] eAddr, ePc;
    logic        eOe, eValid, mPush, mPop;
    logic [2:0]  eCount;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    q_ready        = rdy;
    #4;
    eAddr  = mPc;
    eOe    = !r && !rv && (sbq.size() != 4);
    eValid = !r && (sbq.size() != 0);
    ePc    = eValid ? sbq[0] : 16'h0000;
    eCount = r ? 3'd0 : 3'(sbq.size());
    if (mode == MODE_TABLE) begin
      eAddr  = v.eAddr;
      eOe    = v.eOe;
      eValid = v.eValid;
      ePc    = v.ePc;
      eCount = v.eCount;
    end
    if (mode != MODE_NONE) begin
      checkOutput({tag, ".i_addr"},  32'(i_addr),  32'(eAddr));
      checkOutput({tag, ".i_oe"},    32'(i_oe),    32'(eOe));
      checkOutput({tag, ".q_valid"}, 32'(q_valid), 32'(eValid));
      checkOutput({tag, ".q_pc"},    32'(q_pc),    32'(ePc));
      checkOutput({tag, ".q_instr"}, 32'(q_instr), 32'(ePc));
      checkOutput({tag, ".q_count"}, 32'(q_count), 32'(eCount));
    end
    if (capture && q_valid && q_ready) capQ.push_back(q_pc);
    mPush = !r && !rv && (sbq.size() != 4);
    mPop  = !r && (sbq.size() != 0) && rdy;
    @(posedge clk);
    if (r) begin
      mPc = 16'h0000;
      sbq.delete();
    end else if (rv) begin
      mPc = rpc;
      sbq.delete();
    end else begin
      if (mPop) void'(sbq.pop_front());
      if (mPush) begin
        sbq.push_back(mPc);
        mPc = mPc + 16'd2;
      end
    end
    #1;
  endtask

  vec_t vecs [14];
  vec_t blank;
  logic [15:0] wrapExp [4];

  initial begin
    blank = '0;
    //           rst   rv    rpc       rdy   eAddr     eOe   eValid ePc       eCount
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b1, 16'h0000, 3'd1};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000, 3'd2};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 1'b1, 16'h0000, 3'd3};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0, 1'b1, 16'h0000, 3'd4};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 1'b1, 16'h0000, 3'd4};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 1'b1, 16'h0002, 3'd3};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b0, 1'b1, 16'h0002, 3'd4};
    vecs[9]  = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h000A, 1'b0, 1'b1, 16'h0002, 3'd4};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0042, 1'b1, 1'b1, 16'h0040, 3'd1};
    vecs[12] = '{1'b1, 1'b1, 16'h0080, 1'b0, 16'h0044, 1'b0, 1'b0, 16'h0000, 3'd0};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0};
    wrapExp[0] = 16'hFFFC;
    wrapExp[1] = 16'hFFFE;
    wrapExp[2] = 16'h0000;
    wrapExp[3] = 16'h0002;

    mPc = 16'h0000;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    q_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, MODE_TABLE, vecs[i],
                    $sformatf("vec%0d", i));
    end

    // Streaming: one pop per cycle with no bubbles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, MODE_MODEL, blank, $sformatf("stream%0d", i));
    end

    // Address wrap across 0xFFFF.
    applyStimulus(1'b0, 1'b1, 16'hFFFC, 1'b0, MODE_MODEL, blank, "wrapRedir");
    capture = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, MODE_MODEL, blank, $sformatf("wrap%0d", i));
    end
    capture = 1'b0;
    checkOutput("wrap.len", 32'(capQ.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrap.pc%0d", i), 32'((capQ.size() > i) ? capQ[i] : 16'hDEAD),
                  32'(wrapExp[i]));
    end

    // Redirect held for several cycles.
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b1, MODE_MODEL, blank, "hold0");
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0, MODE_MODEL, blank, "hold1");
    applyStimulus(1'b0, 1'b1, 16'h0300, 1'b1, MODE_MODEL, blank, "hold2");
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, MODE_MODEL, blank, "hold3");
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, MODE_MODEL, blank, "hold4");

    // Random traffic with occasional redirects and resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                    16'($urandom_range(0, 65535)) & 16'hFFFE, 1'($urandom_range(0, 1)),
                    MODE_MODEL, blank, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
